// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-port adapter with a 2-entry skid buffer feeding a valid/ready stream
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      xfer_cnt,
  output logic                  err_underflow,
  output logic                  idle
);

  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_W-1:0]      xfer_cnt_q, xfer_cnt_d;
  logic                  err_q, err_d;
  logic                  pop;
  logic                  cap;
  logic [1:0]            occ;

  assign pop = (buf_cnt_q != 2'd0) && m_ready;
  assign cap = inflight_q;
  assign occ = buf_cnt_q + {1'b0, inflight_q};

  // A read is only issued when a slot is guaranteed for its data one cycle later.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (rst_n && enable && !fifo_empty) begin
      fifo_rd_en = (occ < 2'd2) || ((occ == 2'd2) && pop);
    end
  end

  always_comb begin
    buf_cnt_d = buf_cnt_q;
    head_d    = head_q;
    tail_d    = tail_q;
    case (buf_cnt_q)
      2'd0: begin
        if (cap) begin
          head_d    = fifo_data_out;
          buf_cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (cap && !pop) begin
          tail_d    = fifo_data_out;
          buf_cnt_d = 2'd2;
        end else if (cap && pop) begin
          head_d = fifo_data_out;
        end else if (pop) begin
          buf_cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (cap) begin
            tail_d = fifo_data_out;
          end else begin
            buf_cnt_d = 2'd1;
          end
        end
      end
      default: buf_cnt_d = 2'd0;
    endcase
  end

  always_comb begin
    inflight_d = fifo_rd_en;
    xfer_cnt_d = xfer_cnt_q + {{(CNT_W-1){1'b0}}, pop};
    err_d      = err_q | fifo_underflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_cnt_q  <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      xfer_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      buf_cnt_q  <= buf_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      xfer_cnt_q <= xfer_cnt_d;
      err_q      <= err_d;
    end
  end

  assign m_valid       = (buf_cnt_q != 2'd0);
  assign m_data        = head_q;
  assign idle          = (buf_cnt_q == 2'd0) && !inflight_q;
  assign xfer_cnt      = xfer_cnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed and randomized bench for fifo_rd_stream against a queue-based FIFO model
module tb_fifo_rd_stream;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        fifo_rd_en;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_data_out = 16'h0;
  logic        fifo_underflow = 1'b0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;
  logic [15:0] xfer_cnt;
  logic        err_underflow;
  logic        idle;

  logic        enable4;
  logic        fifo_rd_en4;
  logic        m_valid4;
  logic [15:0] m_data4;
  logic [3:0]  xfer_cnt4;
  logic        err_underflow4;
  logic        idle4;
  logic [15:0] fifo_data_out4;

  fifo_rd_stream #(.FIFO_WIDTH(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_rd_en(fifo_rd_en),
    .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .xfer_cnt(xfer_cnt),
    .err_underflow(err_underflow), .idle(idle)
  );

  fifo_rd_stream #(.FIFO_WIDTH(16), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable4), .fifo_rd_en(fifo_rd_en4),
    .fifo_empty(1'b0), .fifo_data_out(fifo_data_out4), .fifo_underflow(1'b0),
    .m_valid(m_valid4), .m_data(m_data4), .m_ready(1'b1), .xfer_cnt(xfer_cnt4),
    .err_underflow(err_underflow4), .idle(idle4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural FIFO: src[] is the word sequence, wp models the producer, rp the reads.
  logic [15:0] src [1024];
  int          src_len = 0;
  int          preload_n = 0;
  int          wr_rate = 0;
  logic        fifo_load = 1'b0;
  logic        force_uf = 1'b0;
  int          rp = 0;
  int          wp = 0;
  int          wr_roll = 0;
  logic        rd_ok;
  logic        wr_ok;

  assign rd_ok = fifo_rd_en && (rp != wp);
  assign wr_ok = (wp < src_len) && (wr_roll < wr_rate);

  always @(negedge clk) wr_roll <= $urandom_range(99);

  always @(posedge clk) begin
    fifo_underflow <= force_uf;
    if (fifo_load) begin
      rp         <= 0;
      wp         <= preload_n;
      fifo_empty <= (preload_n == 0);
    end else begin
      if (fifo_rd_en) begin
        if (rp != wp) fifo_data_out <= src[rp];
        else fifo_underflow <= 1'b1;
      end
      rp         <= rp + (rd_ok ? 1 : 0);
      wp         <= wp + (wr_ok ? 1 : 0);
      fifo_empty <= ((rp + (rd_ok ? 1 : 0)) == (wp + (wr_ok ? 1 : 0)));
    end
  end

  // Observation log taken mid-cycle.
  int          cyc = 0;
  logic [15:0] got [$];
  int          hs_cyc [$];
  int          rd_cyc [$];
  int          stab_err = 0;
  logic        hold_prev = 1'b0;
  logic [15:0] hold_data = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;
  assign fifo_data_out4 = cyc[15:0];

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_rd_en) rd_cyc.push_back(cyc);
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        hs_cyc.push_back(cyc);
      end
      if (hold_prev && (!m_valid || m_data !== hold_data)) stab_err <= stab_err + 1;
      hold_prev <= m_valid && !m_ready;
      hold_data <= m_data;
    end else begin
      hold_prev <= 1'b0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int gb, rb, mism, issued4, pops4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input int pre, input int rate, input logic [15:0] base, input bit rnd);
    for (int i = 0; i < n; i++) src[i] = rnd ? 16'($urandom) : base + 16'(i);
    src_len   = n;
    preload_n = pre;
    wr_rate   = rate;
    fifo_load = 1'b1;
    step(1);
    fifo_load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; enable4 = 1'b0;
    step(3);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 16'h0);
    chk("rst_xfer_cnt", xfer_cnt, 16'h0);
    chk("rst_err", err_underflow, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    rst_n = 1'b1;
    step(2);

    // Streaming at full rate
    load(8, 8, 0, 16'h0001, 1'b0);
    gb = got.size(); rb = rd_cyc.size();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 60 && got.size() - gb < 8; i++) step(1);
    step(3);
    chk("stream_count", got.size() - gb, 8);
    chk("stream_reads", rd_cyc.size() - rb, 8);
    if (got.size() - gb >= 8) begin
      chk("stream_latency", hs_cyc[gb] - rd_cyc[rb], 2);
      chk("stream_back_to_back", hs_cyc[gb+7] - hs_cyc[gb], 7);
      for (int i = 0; i < 8; i++) chk($sformatf("stream_word%0d", i), got[gb+i], 16'(i + 1));
    end
    chk("stream_xfer_cnt", xfer_cnt, 16'd8);
    chk("stream_idle", idle, 1'b1);

    // Backpressure with 4 queued words
    enable = 1'b0; m_ready = 1'b0;
    load(4, 4, 0, 16'h0001, 1'b0);
    gb = got.size(); rb = rd_cyc.size();
    enable = 1'b1;
    step(10);
    chk("bp_reads", rd_cyc.size() - rb, 2);
    chk("bp_m_valid", m_valid, 1'b1);
    chk("bp_m_data", m_data, 16'h0001);
    chk("bp_no_pop", got.size() - gb, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 30 && got.size() - gb < 4; i++) step(1);
    step(4);
    chk("bp_count", got.size() - gb, 4);
    if (got.size() - gb >= 4)
      for (int i = 0; i < 4; i++) chk($sformatf("bp_word%0d", i), got[gb+i], 16'(i + 1));
    chk("bp_xfer_cnt", xfer_cnt, 16'd12);
    chk("bp_stable", stab_err, 0);

    // Enable held for exactly one read
    enable = 1'b0;
    load(3, 3, 0, 16'h00A1, 1'b0);
    gb = got.size(); rb = rd_cyc.size();
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(10);
    chk("en_reads", rd_cyc.size() - rb, 1);
    chk("en_count", got.size() - gb, 1);
    if (got.size() - gb >= 1) chk("en_word", got[gb], 16'h00A1);
    chk("en_idle", idle, 1'b1);

    // Random producer rate, enable and backpressure
    load(1000, 0, 60, 16'h0, 1'b1);
    gb = got.size();
    for (int i = 0; i < 20000 && got.size() - gb < 1000; i++) begin
      enable  = ($urandom_range(99) < 85);
      m_ready = ($urandom_range(99) < 60);
      step(1);
    end
    enable = 1'b0; m_ready = 1'b1;
    step(5);
    chk("rand_count", got.size() - gb, 1000);
    mism = 0;
    for (int i = 0; i < 1000 && gb + i < got.size(); i++) if (got[gb+i] !== src[i]) mism++;
    chk("rand_order", mism, 0);
    chk("rand_stable", stab_err, 0);
    chk("rand_err", err_underflow, 1'b0);
    chk("rand_idle", idle, 1'b1);
    chk("rand_xfer_cnt", xfer_cnt, 16'd1013);

    // Sticky underflow flag
    force_uf = 1'b1;
    step(1);
    force_uf = 1'b0;
    step(2);
    chk("uf_set", err_underflow, 1'b1);
    step(5);
    chk("uf_sticky", err_underflow, 1'b1);

    // Reset with a full buffer
    m_ready = 1'b0;
    load(6, 6, 0, 16'h0100, 1'b0);
    enable = 1'b1;
    step(6);
    chk("mr_full_valid", m_valid, 1'b1);
    chk("mr_full_data", m_data, 16'h0100);
    m_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mr_m_valid", m_valid, 1'b0);
    chk("mr_idle", idle, 1'b1);
    chk("mr_xfer_cnt", xfer_cnt, 16'h0);
    chk("mr_rd_en", fifo_rd_en, 1'b0);
    chk("mr_m_data", m_data, 16'h0);
    chk("mr_err", err_underflow, 1'b0);
    step(2);
    enable = 1'b0; m_ready = 1'b0;
    rst_n = 1'b1;
    step(2);
    chk("mr_after_idle", idle, 1'b1);

    // 4-bit counter wrap over 17 words
    issued4 = 0; pops4 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      enable4 = (issued4 < 17);
      #1;
      if (fifo_rd_en4) issued4++;
      if (m_valid4) pops4++;
    end
    enable4 = 1'b0;
    chk("wrap_pops", pops4, 17);
    chk("wrap_xfer_cnt", xfer_cnt4, 4'd1);
    chk("wrap_idle", idle4, 1'b1);
    chk("wrap_err", err_underflow4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side consumer for the synchronous FIFO: drives the FIFO read port (`rd_en`, `data_out`, `empty`, `underflow`) and presents the words as a valid/ready stream to downstream logic. A 2-entry skid buffer absorbs the FIFO's one-cycle read latency, so the stream sustains one word per clock under continuous `m_ready`. The block also keeps a count of delivered words and a sticky underflow error flag. It sits between the FIFO instance and any consumer that applies backpressure.

## Interface
- `FIFO_WIDTH`, 16: data width. Must match the FIFO.
- `CNT_W`, 16: width of the delivered-word counter.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new FIFO reads. Reads already in flight always complete.
- `fifo_rd_en`  out  1  read strobe to the FIFO; combinational.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data_out`  in  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted read.
- `fifo_underflow`  in  1  FIFO underflow flag.
- `m_valid`  out  FIFO_WIDTH-independent, 1  stream data valid; registered.
- `m_data`  out  FIFO_WIDTH  stream data (head of the skid buffer); registered.
- `m_ready`  in  1  downstream accept.
- `xfer_cnt`  out  CNT_W  number of completed stream handshakes; wraps modulo 2^CNT_W.
- `err_underflow`  out  1  sticky; set when `fifo_underflow` is sampled high.
- `idle`  out  1  high when the buffer is empty and no read is in flight.

## Operation
- **State**
  - `buf_cnt` (0..2): number of words held.
  - `head` / `tail`: the two word registers.
  - `inflight` (0/1): registered copy of `fifo_rd_en`.
- **Events**
  - pop = `m_valid && m_ready`.
  - cap = `inflight`; the word is taken from `fifo_data_out`.
- **Read issue**
  - Let occ = `buf_cnt + inflight`.
  - `fifo_rd_en = enable && !fifo_empty && (occ < 2 || (occ == 2 && pop))`.
  - This credit rule guarantees a captured word always has a free slot.
- **Buffer update**, evaluated on (buf_cnt, pop, cap):
  - 0, cap: `head <= data`, count becomes 1.
  - 1, cap without pop: `tail <= data`, count becomes 2.
  - 1, pop and cap: `head <= data`, count stays 1.
  - 1, pop without cap: count becomes 0.
  - 2, pop and cap: `head <= tail`, `tail <= data`, count stays 2.
  - 2, pop without cap: `head <= tail`, count becomes 1.
- **Outputs**
  - `m_valid = (buf_cnt != 0)`.
  - `m_data = head`.
  - `idle = (buf_cnt == 0) && !inflight`.
- **Counters and flags**
  - `xfer_cnt` increments by 1 on every pop and wraps from all-ones to 0.
  - `err_underflow` is set on any cycle where `fifo_underflow == 1`. It is cleared only by reset. The credit rule means it must never set in correct operation.

## Timing
- **Reset values:** `m_valid=0`, `m_data=0`, `xfer_cnt=0`, `err_underflow=0`, `idle=1`. Internally `buf_cnt=0` and `inflight=0`. `fifo_rd_en` is 0 while `rst_n=0`.
- **Latency:** a read issued in cycle N gives data on `fifo_data_out` in N+1. The word is captured at the end of N+1, and `m_valid` is high in N+2 with an empty buffer.
- **Throughput:** with `m_ready` held high and the FIFO never empty, a pop and a read occur every cycle, steady state.
- **Handshake rules**
  - While `m_valid && !m_ready`, `m_data` and `m_valid` hold stable.
  - `m_valid` never falls without a pop.
- **Backpressure:** `m_ready=0` with the buffer full and nothing in flight drives `fifo_rd_en=0`. At most 2 words are held, and no read is lost.
- **`enable` falling:** no new reads are issued. An in-flight word is still captured and delivered.
- **FIFO empty:** `fifo_rd_en` stays 0 regardless of credit. The adapter never intentionally reads an empty FIFO.
- **Reset mid-operation:** buffered and in-flight words are discarded. All outputs return to their reset values immediately (asynchronously).

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with `buf_cnt=2`. Required: `m_valid=0`, `idle=1`, `xfer_cnt=0`, `fifo_rd_en=0` immediately.
- **Streaming:** preload the FIFO with 0x0001..0x0008, `enable=1`, `m_ready=1`. Required: first `m_valid` 2 cycles after the first `fifo_rd_en`, then 8 consecutive-cycle handshakes in order, then `xfer_cnt=8` and `idle=1`.
- **Backpressure:** 4 words queued, `m_ready=0` for 10 cycles. Required: exactly 2 reads issued, `m_data=0x0001` stable throughout. After `m_ready=1`, words 1..4 are delivered in order with no duplicates.
- **Random backpressure:** toggle `m_ready` randomly over 1000 words. Required: the output sequence matches the input, and `err_underflow` stays 0.
- **Enable drop:** drop `enable` the cycle after a read is issued. Required: that word is still delivered, and no further `fifo_rd_en` occurs.
- **Error and wrap:** force `fifo_underflow=1` for one cycle. Required: `err_underflow=1` until reset. Separately, with `CNT_W=4`, deliver 17 words. Required: `xfer_cnt=1`.
